// File: rtl/forward_ctrl_ysyx23060136.sv
// Hazard controller: stall/flush sequencing for the five-stage pipeline.
// Optional event counters are built only when FORWARD_PERF_CNT_EN is defined.
module forward_ctrl_ysyx23060136 #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IFU_o_valid,
    input  logic              IFU_o_busy,
    input  logic [4:0]        ID_o_rs1,
    input  logic [4:0]        ID_o_rs2,
    input  logic              ID_o_rs1_used,
    input  logic              ID_o_rs2_used,
    input  logic [4:0]        EX_o_rd,
    input  logic              EX_o_mem_to_reg,
    input  logic              EX_o_redirect,
    input  logic              MEM_o_mem_req,
    input  logic              MEM_i_mem_done,
    input  logic              WB_i_system_halt,
    output logic              FORWARD_stallIF,
    output logic              FORWARD_stallID,
    output logic              FORWARD_stallEX,
    output logic              FORWARD_stallME,
    output logic              FORWARD_stallWB,
    output logic              FORWARD_flushIF,
    output logic              FORWARD_flushID,
    output logic              FORWARD_flushEX,
    output logic              FORWARD_flushME,
    output logic              FORWARD_halted,
    output logic [PERF_W-1:0] PERF_mem_stall,
    output logic [PERF_W-1:0] PERF_lu_bubble,
    output logic [PERF_W-1:0] PERF_redirect,
    output logic [PERF_W-1:0] PERF_fetch_wait
);

    typedef enum logic { M_IDLE, M_WAIT } mem_state_t;
    typedef enum logic { F_RUN, F_DISCARD } fetch_state_t;

    mem_state_t   mem_state_reg, mem_state_next;
    fetch_state_t fetch_state_reg, fetch_state_next;
    logic         halted_reg, halted_next;

    logic mem_stall;
    logic lu;
    logic fw;
    logic sel_halt, sel_mem, sel_redirect, sel_lu, sel_fw;

    assign mem_stall = ((mem_state_reg == M_IDLE) &  MEM_o_mem_req) |
                       ((mem_state_reg == M_WAIT) & ~MEM_i_mem_done);

    assign lu = EX_o_mem_to_reg & (EX_o_rd != 5'd0) &
                ((ID_o_rs1_used & (ID_o_rs1 == EX_o_rd)) |
                 (ID_o_rs2_used & (ID_o_rs2 == EX_o_rd)));

    assign fw = ~IFU_o_valid | (fetch_state_reg == F_DISCARD);

    // One-hot row select; reset masks every row so all outputs read 0.
    assign sel_halt     = ~rst & (halted_reg | WB_i_system_halt);
    assign sel_mem      = ~rst & ~sel_halt & mem_stall;
    assign sel_redirect = ~rst & ~sel_halt & ~mem_stall & EX_o_redirect;
    assign sel_lu       = ~rst & ~sel_halt & ~mem_stall & ~EX_o_redirect & lu;
    assign sel_fw       = ~rst & ~sel_halt & ~mem_stall & ~EX_o_redirect & ~lu & fw;

    always_comb begin
        mem_state_next = mem_state_reg;
        case (mem_state_reg)
            M_IDLE:  if (MEM_o_mem_req)  mem_state_next = M_WAIT;
            M_WAIT:  if (MEM_i_mem_done) mem_state_next = M_IDLE;
            default: mem_state_next = M_IDLE;
        endcase
    end

    // A redirect issued while a fetch is in flight leaves a stale response
    // still to come; it must be swallowed rather than decoded.
    always_comb begin
        fetch_state_next = fetch_state_reg;
        case (fetch_state_reg)
            F_RUN:     if (sel_redirect & IFU_o_busy & ~IFU_o_valid)
                           fetch_state_next = F_DISCARD;
            F_DISCARD: if (IFU_o_valid) fetch_state_next = F_RUN;
            default:   fetch_state_next = F_RUN;
        endcase
    end

    assign halted_next = halted_reg | WB_i_system_halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_state_reg   <= M_IDLE;
            fetch_state_reg <= F_RUN;
            halted_reg      <= 1'b0;
        end else begin
            mem_state_reg   <= mem_state_next;
            fetch_state_reg <= fetch_state_next;
            halted_reg      <= halted_next;
        end
    end

    always_comb begin
        FORWARD_stallIF = sel_halt | sel_mem | sel_lu | sel_fw;
        FORWARD_stallID = sel_halt | sel_mem | sel_lu;
        FORWARD_stallEX = sel_halt | sel_mem;
        FORWARD_stallME = sel_halt | sel_mem;
        FORWARD_stallWB = sel_halt;
        FORWARD_flushIF = sel_redirect | sel_fw;
        FORWARD_flushID = sel_redirect | sel_lu;
        FORWARD_flushEX = 1'b0;
        FORWARD_flushME = sel_mem;
        FORWARD_halted  = sel_halt & halted_reg;
    end

`ifdef FORWARD_PERF_CNT_EN
    logic [3:0] perf_evt;
    assign perf_evt = {sel_fw, sel_lu, sel_redirect, sel_mem};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_cnt
            logic [PERF_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else if (perf_evt[gi])
                    cnt_reg <= cnt_reg + PERF_W'(1);
            end
        end
    endgenerate

    assign PERF_mem_stall  = gen_cnt[0].cnt_reg;
    assign PERF_redirect   = gen_cnt[1].cnt_reg;
    assign PERF_lu_bubble  = gen_cnt[2].cnt_reg;
    assign PERF_fetch_wait = gen_cnt[3].cnt_reg;
`else
    assign PERF_mem_stall  = '0;
    assign PERF_redirect   = '0;
    assign PERF_lu_bubble  = '0;
    assign PERF_fetch_wait = '0;
`endif

endmodule

// File: tb/tb_forward_ctrl_ysyx23060136.sv
// Directed bench for forward_ctrl_ysyx23060136; counter expectations follow
// FORWARD_PERF_CNT_EN (zero when the counters are not built).
module tb_forward_ctrl_ysyx23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic        IFU_o_valid, IFU_o_busy;
    logic [4:0]  ID_o_rs1, ID_o_rs2, EX_o_rd;
    logic        ID_o_rs1_used, ID_o_rs2_used;
    logic        EX_o_mem_to_reg, EX_o_redirect;
    logic        MEM_o_mem_req, MEM_i_mem_done, WB_i_system_halt;
    logic        s_if, s_id, s_ex, s_me, s_wb, f_if, f_id, f_ex, f_me, halted;
    logic [31:0] p_mem, p_lu, p_red, p_fw;

    int errors = 0;
    int checks = 0;

`ifdef FORWARD_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // {stallIF,stallID,stallEX,stallME,stallWB,flushIF,flushID,flushEX,flushME,halted}
    localparam logic [9:0] O_NONE  = 10'b00000_0000_0;
    localparam logic [9:0] O_LU    = 10'b11000_0100_0;
    localparam logic [9:0] O_MEM   = 10'b11110_0001_0;
    localparam logic [9:0] O_REDIR = 10'b00000_1100_0;
    localparam logic [9:0] O_FW    = 10'b10000_1000_0;
    localparam logic [9:0] O_HALT0 = 10'b11111_0000_0;
    localparam logic [9:0] O_HALT1 = 10'b11111_0000_1;

    logic [9:0] outv;
    assign outv = {s_if, s_id, s_ex, s_me, s_wb, f_if, f_id, f_ex, f_me, halted};

    forward_ctrl_ysyx23060136 #(.PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .IFU_o_valid(IFU_o_valid), .IFU_o_busy(IFU_o_busy),
        .ID_o_rs1(ID_o_rs1), .ID_o_rs2(ID_o_rs2),
        .ID_o_rs1_used(ID_o_rs1_used), .ID_o_rs2_used(ID_o_rs2_used),
        .EX_o_rd(EX_o_rd), .EX_o_mem_to_reg(EX_o_mem_to_reg),
        .EX_o_redirect(EX_o_redirect),
        .MEM_o_mem_req(MEM_o_mem_req), .MEM_i_mem_done(MEM_i_mem_done),
        .WB_i_system_halt(WB_i_system_halt),
        .FORWARD_stallIF(s_if), .FORWARD_stallID(s_id), .FORWARD_stallEX(s_ex),
        .FORWARD_stallME(s_me), .FORWARD_stallWB(s_wb),
        .FORWARD_flushIF(f_if), .FORWARD_flushID(f_id), .FORWARD_flushEX(f_ex),
        .FORWARD_flushME(f_me), .FORWARD_halted(halted),
        .PERF_mem_stall(p_mem), .PERF_lu_bubble(p_lu),
        .PERF_redirect(p_red), .PERF_fetch_wait(p_fw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Sample combinational outputs mid-cycle, after inputs have settled.
    task automatic chk_out(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, {22'd0, outv}, {22'd0, exp});
    endtask

    task automatic chk_perf(input string tag, input int m, input int l, input int r, input int f);
        @(negedge clk);
        check({tag, ".mem"}, p_mem, PERF_ON ? 32'(m) : 32'd0);
        check({tag, ".lu"},  p_lu,  PERF_ON ? 32'(l) : 32'd0);
        check({tag, ".red"}, p_red, PERF_ON ? 32'(r) : 32'd0);
        check({tag, ".fw"},  p_fw,  PERF_ON ? 32'(f) : 32'd0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IFU_o_valid = 1'b1; IFU_o_busy = 1'b0;
        ID_o_rs1 = 5'd0; ID_o_rs2 = 5'd0; ID_o_rs1_used = 1'b0; ID_o_rs2_used = 1'b0;
        EX_o_rd = 5'd0; EX_o_mem_to_reg = 1'b0; EX_o_redirect = 1'b0;
        MEM_o_mem_req = 1'b0; MEM_i_mem_done = 1'b0; WB_i_system_halt = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Reset masks even active hazard inputs
        MEM_o_mem_req = 1'b1; WB_i_system_halt = 1'b1; EX_o_redirect = 1'b1;
        next();
        chk_out("rst_outputs", O_NONE);
        next();
        idle_inputs();
        rst = 1'b0;
        chk_out("post_rst", O_NONE);
        chk_perf("perf_rst", 0, 0, 0, 0);

        // Load-use on rs1: exactly one bubble
        next();
        EX_o_mem_to_reg = 1'b1; EX_o_rd = 5'd5; ID_o_rs1 = 5'd5; ID_o_rs1_used = 1'b1;
        chk_out("lu_rs1", O_LU);
        next();
        idle_inputs();
        chk_out("lu_rs1_release", O_NONE);

        // Load-use on rs2; rs1 matching but unused must not trigger
        next();
        EX_o_mem_to_reg = 1'b1; EX_o_rd = 5'd7; ID_o_rs2 = 5'd7; ID_o_rs2_used = 1'b1;
        chk_out("lu_rs2", O_LU);
        next();
        ID_o_rs2_used = 1'b0; ID_o_rs1 = 5'd7; ID_o_rs1_used = 1'b0;
        chk_out("lu_rs1_unused", O_NONE);
        next();
        EX_o_rd = 5'd0; ID_o_rs1 = 5'd0; ID_o_rs1_used = 1'b1;
        chk_out("lu_rd_x0", O_NONE);

        // Bus access, done 3 cycles after request
        next();
        idle_inputs();
        MEM_o_mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("mem_wait%0d", i), O_MEM);
            next();
        end
        MEM_i_mem_done = 1'b1;
        chk_out("mem_done", O_NONE);
        next();
        idle_inputs();
        chk_out("mem_after", O_NONE);

        // Redirect with outstanding fetch: stale response is discarded
        next();
        EX_o_redirect = 1'b1; IFU_o_busy = 1'b1; IFU_o_valid = 1'b0;
        chk_out("redir_busy", O_REDIR);
        next();
        idle_inputs();
        chk_out("redir_discard", O_FW);
        next();
        chk_out("redir_accept", O_NONE);

        // Plain fetch wait
        next();
        IFU_o_valid = 1'b0; IFU_o_busy = 1'b1;
        chk_out("fetch_wait", O_FW);

        // Redirect under a memory stall waits for the release
        next();
        idle_inputs();
        MEM_o_mem_req = 1'b1; EX_o_redirect = 1'b1;
        chk_out("redir_mem", O_MEM);
        next();
        MEM_i_mem_done = 1'b1;
        chk_out("redir_after_mem", O_REDIR);
        next();
        idle_inputs();
        chk_out("redir_mem_clear", O_NONE);

        // Redirect outranks an (illegal) coincident load-use
        next();
        EX_o_redirect = 1'b1; EX_o_mem_to_reg = 1'b1; EX_o_rd = 5'd3;
        ID_o_rs1 = 5'd3; ID_o_rs1_used = 1'b1;
        chk_out("redir_over_lu", O_REDIR);
        next();
        idle_inputs();
        chk_perf("perf_mid", 4, 2, 3, 2);

        // Redirect into F_DISCARD, then reset abandons it
        next();
        EX_o_redirect = 1'b1; IFU_o_busy = 1'b1; IFU_o_valid = 1'b0;
        chk_out("redir_pre_rst", O_REDIR);
        next();
        idle_inputs();
        rst = 1'b1;
        next();
        rst = 1'b0;
        chk_out("discard_abandoned", O_NONE);

        // Halt pulse, frozen for 5 cycles, bus request into M_WAIT meanwhile
        next();
        WB_i_system_halt = 1'b1;
        chk_out("halt_pulse", O_HALT0);
        next();
        idle_inputs();
        MEM_o_mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("halted%0d", i), O_HALT1);
            next();
        end
        idle_inputs();
        rst = 1'b1;
        chk_out("halt_rst", O_NONE);
        next();
        rst = 1'b0;
        chk_out("after_halt_rst", O_NONE);
        chk_perf("perf_after_rst", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
